// File: rtl/acc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : acc_mem_responder
// Brief    : Memory-side target for the accumulator CPU control FSM. Accepts
//            one load/store at a time, decodes it to data RAM / IOIn / IOOut,
//            waits a programmable number of cycles, then returns a response.
// Revision : 1.0 - initial release
// ============================================================================
module acc_mem_responder #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [15:0] IO_IN_ADDR  = 16'hFFF0,
  parameter logic [15:0] IO_OUT_ADDR = 16'hFFF2,
  parameter int          WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [15:0]           ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspErr,
  input  logic [DATA_WIDTH-1:0] IOIn,
  output logic [DATA_WIDTH-1:0] IOOut,
  output logic                  IOOutStrobe
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // Wait-state counter reload value; legal WAIT_STATES range fits in 4 bits.
  localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);
  localparam int         C_DEPTH     = 2 ** ADDR_WIDTH;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] io_out_q, io_out_d;
  logic                  io_out_strobe_q, io_out_strobe_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic                  ram_hit;
  logic [DATA_WIDTH-1:0] mem [0:C_DEPTH-1];

  // Only addresses below the RAM depth land in the array.
  assign ram_hit = (addr_q >> ADDR_WIDTH) == 16'd0;
  assign mem_idx = addr_q[ADDR_WIDTH-1:0];

  assign ReqReady    = (state_q == ST_IDLE);
  assign RspValid    = (state_q == ST_RESPOND);
  assign RspData     = rsp_data_q;
  assign RspErr      = rsp_err_q;
  assign IOOut       = io_out_q;
  assign IOOutStrobe = io_out_strobe_q;

  // Next-state logic: accept, count wait states, commit the access, respond.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    write_d         = write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    io_out_d        = io_out_q;
    io_out_strobe_d = 1'b0;
    mem_we          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          addr_d  = ReqAddr;
          wdata_d = ReqData;
          cnt_d   = C_WAIT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit edge: decode, perform the side effect, register response.
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (ram_hit) begin
            if (write_q) mem_we = 1'b1;
            else         rsp_data_d = mem[mem_idx];
          end else if (addr_q == IO_IN_ADDR) begin
            if (write_q) rsp_err_d  = 1'b1;
            else         rsp_data_d = IOIn;
          end else if (addr_q == IO_OUT_ADDR) begin
            if (write_q) begin
              io_out_d        = wdata_q;
              io_out_strobe_d = 1'b1;
            end else begin
              rsp_data_d = io_out_q;
            end
          end else begin
            rsp_err_d = 1'b1;
          end
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (RspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, response and IO registers; reset drops any in-flight request.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      write_q         <= 1'b0;
      addr_q          <= 16'd0;
      wdata_q         <= '0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      io_out_q        <= '0;
      io_out_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      io_out_q        <= io_out_d;
      io_out_strobe_q <= io_out_strobe_d;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_idx] <= wdata_q;
  end

endmodule
`default_nettype wire

// File: doc/acc_mem_responder.md
Name: acc_mem_responder

Overview:
Memory-side responder for the accumulator CPU's multicycle control FSM. It accepts one word-wide load/store request at a time over a valid/ready handshake. Each request is decoded to the on-chip data RAM, the input port or the output port. The block inserts a programmable number of wait states, then returns a response (read data or write acknowledge) over a second valid/ready handshake. The control FSM is the initiator; this block is the target, and it owns the RAM array and the IOIn/IOOut registers.

Parameters:
DATA_WIDTH, 16, word width of RAM, request data and response data
ADDR_WIDTH, 10, RAM depth is 2**ADDR_WIDTH words; RAM occupies word addresses 0 .. 2**ADDR_WIDTH-1
IO_IN_ADDR, 16'hFFF0, address that reads IOIn
IO_OUT_ADDR, 16'hFFF2, address that reads or writes the IOOut register
WAIT_STATES, 1, extra ACCESS cycles per request; legal range 0..15

Ports:
CLK  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-high reset
ReqValid  input  1  initiator presents a request
ReqReady  output  1  responder can accept a request
ReqWrite  input  1  1 = store, 0 = load
ReqAddr  input  16  word address
ReqData  input  DATA_WIDTH  store data
RspValid  output  1  response available
RspReady  input  1  initiator consumes the response
RspData  output  DATA_WIDTH  load data; 0 for stores and errors
RspErr  output  1  address was unmapped
IOIn  input  DATA_WIDTH  external input port
IOOut  output  DATA_WIDTH  external output register
IOOutStrobe  output  1  one-cycle pulse when IOOut is written

Behaviour:
- Reset (asynchronous, any time):
  - state goes to IDLE
  - ReqReady=1 once released; RspValid=0, RspData=0, RspErr=0, IOOut=0, IOOutStrobe=0, wait counter=0
  - RAM contents are not cleared
- Reset mid-request: the request is dropped. A store whose commit edge has not yet occurred is not performed, and no response is issued.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - ReqReady=1.
  - On an edge with ReqValid=1, latch ReqWrite, ReqAddr and ReqData, load counter=WAIT_STATES, go to ACCESS.
  - ReqData/ReqAddr changes after acceptance have no effect.
- ACCESS:
  - ReqReady=0.
  - While counter≠0, decrement the counter each edge.
  - The edge with counter==0 is the commit edge. It:
    - decodes the address
    - performs the side effect
    - registers RspData/RspErr
    - goes to RESPOND
- Decode at commit (first match wins):
  - addr < 2**ADDR_WIDTH: RAM. A store writes RAM[addr[ADDR_WIDTH-1:0]]; a load captures RAM[addr]. The RAM is synchronous, with read data registered at the commit edge.
  - addr == IO_IN_ADDR: a load captures IOIn as sampled at the commit edge. A store is ignored with RspErr=1 (read-only port).
  - addr == IO_OUT_ADDR: a load returns the current IOOut. A store sets IOOut=data, and IOOutStrobe=1 for exactly the cycle following the commit edge.
  - otherwise: no side effect, RspErr=1, RspData=0.
  - Stores always return RspData=0.
- RESPOND:
  - RspValid=1. RspData and RspErr are held stable until consumed.
  - On an edge with RspReady=1: RspValid drops, state goes to IDLE, ReqReady=1 on the next cycle.
  - A new request is never accepted in the same cycle a response is consumed.
- Latency: request accepted at edge N; commit at edge N+1+WAIT_STATES; RspValid high from cycle N+1+WAIT_STATES until consumed. Minimum turnaround with RspReady tied high is WAIT_STATES+3 cycles per request.
- RspReady asserted outside RESPOND is ignored. ReqValid outside IDLE is ignored; the initiator must hold it until ReqReady.
- Read-after-write to the same RAM address in back-to-back requests returns the new data.

Test Plan:
- Reset asserted asynchronously mid-ACCESS of a store (addr 16'h0005, data 16'hBEEF) -> outputs zero immediately, no response issued; a later load of 5 returns the pre-reset value.
- WAIT_STATES=1: store 16'h1234 to addr 16'h0010, then load 16'h0010 -> RspValid goes high 2 cycles after each accept edge; load RspData=16'h1234, RspErr=0.
- Load addr 16'hFFF0 with IOIn=16'hA5A5 stable at commit, changed to 16'h0000 afterwards -> RspData=16'hA5A5.
- Store 16'h00FF to 16'hFFF2 -> IOOut=16'h00FF after commit, IOOutStrobe high exactly 1 cycle; a following load of 16'hFFF2 returns 16'h00FF.
- Load 16'h0400 (first unmapped address) and store to 16'hFFF0 -> RspErr=1, RspData=0, RAM and IOOut unchanged.
- RspReady held low for 5 cycles in RESPOND with ReqValid asserted -> RspValid and RspData stable, ReqReady=0, second request accepted only after the cycle in which RspReady=1.
